recirc_ctrl: RTL
================

# recirc_ctrl

Main-state controller that sequences the four-lane recirculation datapath. After reset it loads and holds the FIFO almost-full and almost-empty thresholds. It then tracks the four lane FIFOs and drives the datapath's `IDLE` select high only when every lane has drained. Any FIFO overflow or underflow, or an invalid threshold set, locks it into an error state that only reset clears.

## Interface
Parameters:
- `LANES`, 4: number of lane FIFOs monitored.
- `TW`, 3: threshold width in bits.
- `EMPTY_HOLD`, 2: consecutive all-empty cycles required before ACTIVE→IDLE.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  request to (re)enter INIT and reload thresholds.
- `umbral_alto_in`  in  TW  almost-full threshold candidate.
- `umbral_bajo_in`  in  TW  almost-empty threshold candidate.
- `fifo_empty`  in  LANES  per-lane FIFO empty flags.
- `fifo_error`  in  LANES  per-lane overflow/underflow flags.
- `umbral_alto`  out  TW  registered almost-full threshold to FIFOs.
- `umbral_bajo`  out  TW  registered almost-empty threshold to FIFOs.
- `idle`  out  1  drives datapath `IDLE`; high only in IDLE state.
- `active`  out  1  high only in ACTIVE state.
- `error_out`  out  1  high only in ERROR state.
- `state`  out  3  current state code.

## Operation
- State codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Codes 5-7 are illegal; they go to RESET on the next edge.
- Asynchronous reset (`reset_L`=0): state=RESET. `umbral_alto`, `umbral_bajo` and the hold counter clear to 0. `idle`, `active` and `error_out` all read 0.
- RESET: unconditional → INIT on the first posedge with `reset_L`=1.
- INIT:
  - Every posedge in INIT captures `umbral_alto_in`/`umbral_bajo_in` into the outputs.
  - Stay while `init`=1.
  - With `init`=0: if `umbral_bajo_in` ≥ `umbral_alto_in` → ERROR; otherwise → IDLE. The thresholds are still captured on that edge.
- IDLE, evaluated in priority order:
  - any `fifo_error` bit set → ERROR;
  - else `init`=1 → INIT;
  - else any `fifo_empty` bit = 0 → ACTIVE;
  - else stay.
- ACTIVE, evaluated in priority order:
  - any `fifo_error` bit set → ERROR;
  - else `init`=1 → INIT;
  - else if all `fifo_empty` have been 1 for `EMPTY_HOLD` consecutive sampled cycles → IDLE;
  - else stay.
- Hold counter:
  - Counts all-empty samples taken in ACTIVE and saturates at `EMPTY_HOLD`.
  - Clears on any non-empty sample and on any exit from ACTIVE.
- ERROR: sticky. Ignores `init`, `fifo_error` and `fifo_empty`; only `reset_L`=0 leaves it.
- Thresholds hold their value outside INIT; input changes outside INIT have no effect.
- `idle`, `active` and `error_out` are decoded directly from the state register, with no extra register stage. Exactly one of them, or none (RESET/INIT), is high at any time.

## Timing
- All transitions take effect at the posedge following the cycle in which the condition is sampled, so there is one cycle of input-to-state latency.
- Flag outputs change in the same cycle as `state`, with zero additional latency.
- Minimum IDLE→ACTIVE reaction: 1 cycle after the first non-empty sample.
- Minimum ACTIVE→IDLE: `EMPTY_HOLD` all-empty samples, then the transition edge. With the default of 2, `idle` rises 2 cycles after `fifo_empty` becomes 4'hF.
- An error flag and `init` in the same cycle resolve to ERROR. An error flag and a non-empty FIFO in the same cycle also resolve to ERROR.
- A one-cycle non-empty glitch during the ACTIVE hold resets the counter; `idle` then needs a full `EMPTY_HOLD` again.
- `reset_L` asserted mid-operation, in any state, forces RESET and zeroes all outputs immediately, without waiting for a clock. Deassertion takes effect at the next posedge, where RESET→INIT.

## Test plan
- Reset then boot: hold `reset_L`=0, release with `init`=1, alto=6, bajo=2, then drop `init`. Required:
  - `state` goes 0→1→2;
  - `umbral_alto`=6, `umbral_bajo`=2;
  - `idle`=1 one cycle after `init` falls.
- Bad config: exit INIT with alto=3, bajo=3. Required: `state`=4 and `error_out`=1 on the next edge; it stays at 4 despite later `init`=1.
- Traffic: from IDLE drive `fifo_empty`=4'b1011 for 3 cycles, then 4'hF. Required:
  - `active`=1 one cycle after the non-empty sample;
  - `idle`=1 exactly 2 cycles after 4'hF.
- Hold glitch: in ACTIVE drive 4'hF, 4'hE, 4'hF, 4'hF. Required: `idle` rises only after the final two all-empty samples.
- Priority: in ACTIVE drive `fifo_error`=4'b0100 together with `init`=1. Required: `state`=4 next edge; thresholds unchanged.
- Mid-run reset: assert `reset_L`=0 asynchronously while in ACTIVE. Required: `state`=0, all flags 0 and thresholds 0 before the next posedge; then it reboots through INIT.

Source files
------------

// File: rtl/recirc_ctrl.sv
// recirc_ctrl: main-state controller for the four-lane recirculation datapath.
// Loads the almost-full/almost-empty thresholds after reset, tracks the lane
// FIFO empty/error flags, and raises the datapath IDLE select only after every
// lane has drained for EMPTY_HOLD consecutive cycles. Any FIFO error, or an
// invalid threshold pair (bajo >= alto), locks the controller in ERROR until reset.
//
// Ports:
//   clk, reset_L              clock, asynchronous active-low reset
//   init                      request to (re)enter INIT and reload thresholds
//   umbral_alto_in/_bajo_in   threshold candidates, sampled only in INIT
//   fifo_empty, fifo_error    per-lane FIFO status flags
//   umbral_alto/_bajo         registered thresholds driven to the FIFOs
//   idle, active, error_out   one-hot state decode (all low in RESET/INIT)
//   state                     current state code
module recirc_ctrl #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned TW         = 3,
  parameter int unsigned EMPTY_HOLD = 2   // must be >= 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [TW-1:0]    umbral_alto_in,
  input  logic [TW-1:0]    umbral_bajo_in,
  input  logic [LANES-1:0] fifo_empty,
  input  logic [LANES-1:0] fifo_error,
  output logic [TW-1:0]    umbral_alto,
  output logic [TW-1:0]    umbral_bajo,
  output logic             idle,
  output logic             active,
  output logic             error_out,
  output logic [2:0]       state
);

  localparam int unsigned CW = (EMPTY_HOLD < 2) ? 1 : $clog2(EMPTY_HOLD + 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] hold_q;
  logic          all_empty;
  logic          any_err;
  logic          hold_done;

  assign all_empty = &fifo_empty;
  assign any_err   = |fifo_error;
  // This sample completes the run of EMPTY_HOLD all-empty cycles.
  assign hold_done = all_empty && (hold_q >= CW'(EMPTY_HOLD - 1));

  // State, threshold and hold-counter registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= S_RESET;
      umbral_alto <= '0;
      umbral_bajo <= '0;
      hold_q      <= '0;
    end else begin
      // Counter clears unless we stay in ACTIVE on an all-empty sample.
      hold_q <= '0;
      case (state_q)
        S_RESET: state_q <= S_INIT;
        S_INIT: begin
          umbral_alto <= umbral_alto_in;
          umbral_bajo <= umbral_bajo_in;
          if (!init) begin
            state_q <= (umbral_bajo_in >= umbral_alto_in) ? S_ERROR : S_IDLE;
          end
        end
        S_IDLE: begin
          if (any_err)         state_q <= S_ERROR;
          else if (init)       state_q <= S_INIT;
          else if (!all_empty) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (any_err)        state_q <= S_ERROR;
          else if (init)      state_q <= S_INIT;
          else if (hold_done) state_q <= S_IDLE;
          else if (all_empty) begin
            hold_q <= (hold_q >= CW'(EMPTY_HOLD)) ? hold_q : hold_q + CW'(1);
          end
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_RESET;
      endcase
    end
  end

  // Flags decode straight from the state register.
  assign idle      = (state_q == S_IDLE);
  assign active    = (state_q == S_ACTIVE);
  assign error_out = (state_q == S_ERROR);
  assign state     = state_q;

endmodule
